// File: rtl/swap_datapath.sv
// Three-register datapath on a shared bus, driven by the swap controller.
// Adds a host load port, a swap-completion counter and a sticky protocol-error flag.
module swap_datapath #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c1,
  input  logic          c2,
  input  logic          c3,
  input  logic          h1,
  input  logic          h2,
  input  logic          h3,
  input  logic          done,
  input  logic          ld,
  input  logic [1:0]    ld_sel,
  input  logic [W-1:0]  ld_data,
  input  logic          err_clr,
  output logic [W-1:0]  r1,
  output logic [W-1:0]  r2,
  output logic [W-1:0]  r3,
  output logic [W-1:0]  bus,
  output logic [CW-1:0] swap_count,
  output logic          done_pulse,
  output logic          err
);

  logic [1:0] drv_cnt;
  logic       one_drv;
  logic       any_cap;
  logic       any_ctl;
  logic       load_en;
  logic       err_set;
  logic       done_q;
  logic       done_rise;

  assign drv_cnt   = 2'(h1) + 2'(h2) + 2'(h3);
  assign one_drv   = (drv_cnt == 2'd1);
  assign any_cap   = c1 | c2 | c3;
  assign any_ctl   = any_cap | h1 | h2 | h3;
  assign load_en   = ld & ~any_ctl;
  assign done_rise = done & ~done_q;

  // Captures with zero or several drivers, any contention, and loads under activity are protocol errors
  assign err_set = (any_cap & ~one_drv) | (drv_cnt > 2'd1) | (ld & any_ctl);

  // Bus carries the single driver; idle and contention both read as zero
  always_comb begin
    bus = '0;
    if (one_drv) begin
      if (h1)      bus = r1;
      else if (h2) bus = r2;
      else         bus = r3;
    end
  end

  // Register file: bus capture has priority, host load only when all control lines are idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (c1 && one_drv)                     r1 <= bus;
      else if (load_en && ld_sel == 2'd1)    r1 <= ld_data;
      if (c2 && one_drv)                     r2 <= bus;
      else if (load_en && ld_sel == 2'd2)    r2 <= ld_data;
      if (c3 && one_drv)                     r3 <= bus;
      else if (load_en && ld_sel == 2'd3)    r3 <= ld_data;
    end
  end

  // Completion detection: count and strobe once per rising edge of done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      done_pulse <= 1'b0;
      swap_count <= '0;
    end else begin
      done_q     <= done;
      done_pulse <= done_rise;
      if (done_rise) swap_count <= swap_count + CW'(1);
    end
  end

  // Sticky error; a new error in the same cycle as err_clr keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: doc/swap_datapath.md
# swap_datapath

Register datapath driven by the three-cycle swap controller, which sequences the bus in this order: R3<=R2, R2<=R1, R1<=R3. The block holds three W-bit registers on a shared internal bus and captures from the bus per the controller's capture lines (c1..c3) and drive lines (h1..h3). It also provides a host load port, a swap-completion counter and a sticky protocol-error flag, and sits directly downstream of the controller.

## Interface
- W, 8, register and bus width in bits
- CW, 8, swap counter width in bits
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- c1, c2, c3  in  1 each  capture enables: Ri <= bus at the clock edge
- h1, h2, h3  in  1 each  drive enables: Ri drives the bus
- done  in  1  controller completion flag (high during the final swap state)
- ld  in  1  host load request
- ld_sel  in  2  host load target: 1=R1, 2=R2, 3=R3, 0=none
- ld_data  in  W  host load value
- err_clr  in  1  clears the sticky error flag
- r1, r2, r3  out  W each  register contents
- bus  out  W  current bus value (combinational)
- swap_count  out  CW  number of completed swaps, wraps modulo 2^CW
- done_pulse  out  1  registered single-cycle strobe, one per completed swap
- err  out  1  sticky protocol error

## Operation
- Drive count k = h1+h2+h3.
  - k=1: bus = the driving register.
  - k=0: bus = 0.
  - k>1: bus = 0 (contention).
- Capture at the clock edge:
  - Each Ri with ci=1 loads bus only when k=1.
  - Several c lines high with k=1 is legal; all selected registers load (broadcast).
  - Any ci=1 with k≠1 is an error: no register captures and err is set.
  - k>1 with no c line high also sets err.
- Capture and drive of the same register (ci=1 and hi=1) is legal; the register reloads its own value.
- Host load is accepted only when all six control lines are low. It writes ld_data into the register named by ld_sel.
  - ld_sel=0: ignored, no error.
  - ld=1 while any control line is high: load ignored, err set, register values unchanged by ld.
- Completion detection:
  - done_q is done registered by one cycle.
  - Rising edge of done (done=1, done_q=0) increments swap_count and asserts done_pulse for exactly one cycle, at the next edge.
  - done held high for several cycles counts once.
- swap_count wraps from 2^CW-1 to 0 without an error.
- err is sticky until err_clr. If err_clr and a new error occur in the same cycle, set wins and err stays 1.
- Asynchronous reset: r1=r2=r3=0, swap_count=0, done_q=0, done_pulse=0, err=0.
  - bus=0 while all h lines are low.
  - Reset mid-sequence aborts the swap; partial register updates made before reset are lost (all cleared).

## Timing
- Bus is combinational from r1..r3 and h1..h3; zero-cycle latency.
- Register capture and host load take effect at the clock edge where the condition holds; new values are visible on r1..r3 the same cycle after the edge.
- Full swap: three consecutive capture cycles (b, c, d). After the edge ending state d, r1 and r2 hold each other's old values and r3 holds old r2.
- done_pulse and the swap_count update appear one edge after the rising edge of done: the cycle after state d, coinciding with the controller's return to idle.
- err rises at the edge following the offending cycle.
- Reset is asynchronous: outputs clear immediately on rst rising, with no clock required. The first capture is possible at the first clock edge after rst falls.

## Test plan
- Reset: with c/h idle, set r1=0x11 via ld, then pulse rst with no clock running. Required: r1=r2=r3=0, swap_count=0, err=0, done_pulse=0 immediately.
- Normal swap: load R1=0xA5, R2=0x3C, then drive the sequence (c3,h2), (c2,h1), (c1,h3,done), idle. Required: r1=0x3C, r2=0xA5, r3=0x3C; done_pulse high for exactly one cycle; swap_count=1; err=0.
- Contention: with R1=0x0F, R2=0xF0, assert h1=h2=1 and c3=1 for one cycle. Required: bus=0, r3 unchanged, err=1. Then err_clr -> err=0.
- Load during activity: set h2=1 and c3=1, with ld=1, ld_sel=1, ld_data=0x55. Required: r3 takes r2, r1 unchanged, err=1.
- Counter wrap: with CW=2, run 4 swaps. Required: swap_count sequence 1,2,3,0. Also hold done high for 3 cycles: count increments once.
- Reset mid-swap: assert rst during the second step (c2,h1). Required: all registers 0, swap_count unchanged from 0, no done_pulse. A subsequent full swap runs normally.
